// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package bcd_timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Saturate a non-decimal nibble to 9 so the counter only ever holds BCD.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down-counter; digits chain through borrow_i/borrow_o.
module bcd_digit_down
  import bcd_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               dec_en_i,
  input  logic               borrow_i,
  output logic               borrow_o,
  output logic [DIGIT_W-1:0] digit_o
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  // Load wins over decrement; 0 wraps to 9 and passes the borrow upward.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (dec_en_i && borrow_i) begin
      digit_d = (digit_q == 4'd0) ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign borrow_o = borrow_i && (digit_q == 4'd0);
  assign digit_o  = digit_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with start/stop/load control and a done pulse.
// Optional periodic reload on expiry when AUTO_RELOAD_EN is defined.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned N_DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] preset_value,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  running,
  output logic                  zero,
  output logic                  done
);

  localparam int unsigned CW = 4 * N_DIGITS;

  state_e          state_q;
  state_e          state_d;
  logic            done_q;
  logic            done_d;
  logic            running_q;
  logic            dec_en;
  logic            dig_load;
  logic            count_nz;
  logic            reload_nz;
  logic [CW-1:0]   count_w;
  logic [CW-1:0]   preset_clamped;
  logic [CW-1:0]   load_val;
  logic [N_DIGITS:0] borrow;

  // The lowest digit always decrements; the chain's final borrow means all digits are zero.
  assign borrow[0] = 1'b1;
  assign count_nz  = ~borrow[N_DIGITS];

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    assign preset_clamped[4*g +: 4] = clamp_digit(preset_value[4*g +: 4]);

    bcd_digit_down u_digit (
      .clk       (clk),
      .rst_n     (reset),
      .load_i    (dig_load),
      .load_val_i(load_val[4*g +: 4]),
      .dec_en_i  (dec_en),
      .borrow_i  (borrow[g]),
      .borrow_o  (borrow[g+1]),
      .digit_o   (count_w[4*g +: 4])
    );
  end

`ifdef AUTO_RELOAD_EN
  logic [CW-1:0] reload_q;
  logic          reload_hit;

  assign reload_nz  = (reload_q != '0);
  assign reload_hit = done_d && reload_nz;
  assign dig_load   = load || reload_hit;
  assign load_val   = load ? preset_clamped : reload_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= preset_clamped;
    end
  end
`else
  assign reload_nz = 1'b0;
  assign dig_load  = load;
  assign load_val  = preset_clamped;
`endif

  // Control: load > stop > start > tick; a zero reload value behaves like no reload.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    dec_en  = 1'b0;
    if (load) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!stop && start && count_nz) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_PAUSE;
          end else if (tick && count_nz) begin
            dec_en = 1'b1;
            if (count_w == CW'(1)) begin
              done_d  = 1'b1;
              state_d = reload_nz ? S_RUN : S_DONE;
            end
          end
        end
        S_PAUSE: begin
          if (!stop && start) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      running_q <= (state_d == S_RUN);
    end
  end

  assign count   = count_w;
  assign zero    = (count_w == '0);
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (N_DIGITS=2): vector table, corner sequences, random vs model.
module tb_bcd_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] preset_value;
  logic       start;
  logic       stop;
  logic       tick;
  logic [7:0] count;
  logic       running;
  logic       zero;
  logic       done;

  int n_cmp;
  int n_fail;

  bcd_countdown_timer #(.N_DIGITS(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .preset_value(preset_value),
    .start       (start),
    .stop        (stop),
    .tick        (tick),
    .count       (count),
    .running     (running),
    .zero        (zero),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       ld;
    bit [7:0] pv;
    bit       st;
    bit       sp;
    bit       tk;
    bit [7:0] e_count;
    bit       e_run;
    bit       e_done;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: count as a plain decimal integer, state as a small integer.
  int m_val;
  int m_rel;
  int m_st;   // 0 idle, 1 run, 2 pause, 3 done
  bit m_done;
`ifdef AUTO_RELOAD_EN
  localparam bit RELOAD_EN = 1'b1;
`else
  localparam bit RELOAD_EN = 1'b0;
`endif

  function automatic int preset_to_int(input logic [7:0] p);
    int hi;
    int lo;
    hi = (int'(p[7:4]) > 9) ? 9 : int'(p[7:4]);
    lo = (int'(p[3:0]) > 9) ? 9 : int'(p[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] int_to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_val = 0; m_rel = 0; m_st = 0; m_done = 1'b0;
  endtask

  task automatic model_step(input bit ld, input logic [7:0] pv, input bit st, input bit sp, input bit tk);
    m_done = 1'b0;
    if (ld) begin
      m_val = preset_to_int(pv);
      m_rel = m_val;
      m_st  = 0;
    end else if (m_st == 0) begin
      if (st && !sp && m_val != 0) m_st = 1;
    end else if (m_st == 1) begin
      if (sp) m_st = 2;
      else if (tk && m_val > 0) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_done = 1'b1;
          if (RELOAD_EN && m_rel != 0) m_val = m_rel;
          else m_st = 3;
        end
      end
    end else if (m_st == 2) begin
      if (st && !sp) m_st = 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ld, input logic [7:0] pv, input bit st, input bit sp, input bit tk);
    load = ld; preset_value = pv; start = st; stop = sp; tick = tk;
    step();
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic add(input bit ld, input bit [7:0] pv, input bit st, input bit sp, input bit tk,
                     input bit [7:0] ec, input bit er, input bit ed);
    vec_t v;
    v.ld = ld; v.pv = pv; v.st = st; v.sp = sp; v.tk = tk;
    v.e_count = ec; v.e_run = er; v.e_done = ed;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] exp_cnt;
    n_cmp = 0; n_fail = 0;
    load = 0; preset_value = '0; start = 0; stop = 0; tick = 0;
    reset = 1'b0;
    model_reset();

    // Vector table: load 0x12 countdown, invalid digit clamp, pause/resume, load priority.
    add(1, 8'h12, 0, 0, 0, 8'h12, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h12, 1, 0);
    for (int v = 11; v >= 1; v--) add(0, 8'h00, 0, 0, 1, int_to_bcd(v), 1, 0);
`ifdef AUTO_RELOAD_EN
    add(0, 8'h00, 0, 0, 1, 8'h12, 1, 1);
    add(0, 8'h00, 0, 0, 1, 8'h11, 1, 0);
    add(0, 8'h00, 1, 0, 0, 8'h11, 1, 0);
`else
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 1);
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
`endif
    add(1, 8'h5C, 0, 0, 0, 8'h59, 0, 0);
    add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
    add(1, 8'h20, 0, 0, 0, 8'h20, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h20, 1, 0);
    add(0, 8'h00, 0, 1, 1, 8'h20, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h20, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h20, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h19, 1, 0);
    add(1, 8'h40, 0, 0, 0, 8'h40, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h40, 1, 0);
    add(1, 8'h05, 1, 0, 1, 8'h05, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h05, 0, 0);

    #3;
    check("reset_count", 32'(count), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_zero", 32'(zero), 32'h1);
    step();
    #2 reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].pv, vecs[i].st, vecs[i].sp, vecs[i].tk);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].e_run));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].e_count == 8'h00));
    end

    // Asynchronous reset mid-cycle while running at 0x37.
    drive(1, 8'h37, 0, 0, 0);
    drive(0, 8'h00, 1, 0, 0);
    check("async_pre_running", 32'(running), 32'h1);
    #3 reset = 1'b0;
    #1;
    check("async_count", 32'(count), 32'h0);
    check("async_running", 32'(running), 32'h0);
    check("async_done", 32'(done), 32'h0);
    step();
    #2 reset = 1'b1;
    drive(0, 8'h00, 0, 0, 1);
    check("post_reset_done", 32'(done), 32'h0);
    check("post_reset_count", 32'(count), 32'h0);

`ifdef AUTO_RELOAD_EN
    // Periodic reload from 0x03.
    drive(1, 8'h03, 0, 0, 0);
    drive(0, 8'h00, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 8'h00, 0, 0, 1);
      exp_cnt = int_to_bcd((k % 3 == 2) ? 3 : (2 - (k % 3)));
      check($sformatf("reload%0d_count", k), 32'(count), 32'(exp_cnt));
      check($sformatf("reload%0d_done", k), 32'(done), 32'(k % 3 == 2));
      check($sformatf("reload%0d_running", k), 32'(running), 32'h1);
    end
`endif

    // Random stimulus against the behavioural model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int r;
      bit ld, st, sp, tk;
      logic [7:0] pv;
      r = int'($urandom_range(0, 99));
      ld = 0; st = 0; sp = 0; tk = 0;
      pv = 8'($urandom_range(0, 1) != 0 ? $urandom_range(0, 255) : $urandom_range(0, 21));
      if (r < 6) ld = 1;
      else if (r < 16) st = 1;
      else if (r < 21) sp = 1;
      else if (r < 24) begin sp = 1; tk = 1; end
      else if (r < 85) tk = 1;
      if (r >= 85 && r < 88) begin ld = 1; st = 1; tk = 1; end
      model_step(ld, pv, st, sp, tk);
      drive(ld, pv, st, sp, tk);
      exp_cnt = int_to_bcd(m_val);
      check("rnd_count", 32'(count), 32'(exp_cnt));
      check("rnd_running", 32'(running), 32'(m_st == 1));
      check("rnd_done", 32'(done), 32'(m_done));
      check("rnd_zero", 32'(zero), 32'(m_val == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
